// File: rtl/reg_bank_mover_pkg.sv
// Shared definitions for the register bank with MOVE sequencer.
//   mode_e  : op codes applied to the addressed register while Wn is low
//             (3'b110 / 3'b111 are unassigned and leave the register alone)
//   state_e : MOVE sequencer states
//   addr_in_range : address validity test for non-power-of-2 register counts
package reg_bank_pkg;

  typedef enum logic [2:0] {
    MODE_LOAD = 3'b000,
    MODE_CLR  = 3'b001,
    MODE_INC  = 3'b010,
    MODE_DEC  = 3'b011,
    MODE_SHL  = 3'b100,
    MODE_SHR  = 3'b101
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  function automatic logic addr_in_range(input int unsigned addr,
                                         input int unsigned nregs);
    return addr < nregs;
  endfunction

endpackage

// File: rtl/reg_bank_mover_if.sv
// Bus interface for reg_bank_mover.
//   master : driver side (D, Wn, mode, waddr, start, src, dst, raddr out;
//            Q, zero, busy, done in)
//   slave  : register bank side (directions reversed)
interface reg_bank_mover_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREGS = 4
) ();
  localparam int unsigned AW = $clog2(NREGS);

  logic [WIDTH-1:0] D;
  logic             Wn;
  logic [2:0]       mode;
  logic [AW-1:0]    waddr;
  logic             start;
  logic [AW-1:0]    src;
  logic [AW-1:0]    dst;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] Q;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output D, Wn, mode, waddr, start, src, dst, raddr,
    input  Q, zero, busy, done
  );

  modport slave (
    input  D, Wn, mode, waddr, start, src, dst, raddr,
    output Q, zero, busy, done
  );
endinterface

// File: rtl/reg_bank_mover_mode_unit.sv
// Combinational per-register op unit.
//   mode     : op select (mode_e encoding)
//   cur      : current value of the target register
//   d        : data bus value used by LOAD
//   nxt      : value to write back
//   wr_valid : 1 when mode is a defined op; 0 means hold (no write)
module reg_mode_unit
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] nxt,
  output logic             wr_valid
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_comb begin
    nxt      = cur;
    wr_valid = 1'b1;
    case (mode)
      MODE_LOAD: nxt = d;
      MODE_CLR:  nxt = '0;
      MODE_INC:  nxt = cur + ONE;
      MODE_DEC:  nxt = cur - ONE;
      MODE_SHL:  nxt = {cur[WIDTH-2:0], 1'b0};
      MODE_SHR:  nxt = {1'b0, cur[WIDTH-1:1]};
      default:   wr_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/reg_bank_mover.sv
// Parametrised register bank with per-register ops and a MOVE sequencer.
//   clock, reset : single clock, asynchronous active-high reset
//   bus.D/Wn/mode/waddr : Wn-strobed op on register waddr (IDLE only)
//   bus.start/src/dst   : register-to-register MOVE request (IDLE, Wn=1)
//   bus.raddr/Q/zero    : combinational read port, Q=0 for bad raddr
//   bus.busy/done       : MOVE in progress / one-cycle commit pulse
module reg_bank_mover
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREGS = 4
) (
  input  logic           clock,
  input  logic           reset,
  reg_bank_mover_if.slave bus
);

  localparam int unsigned AW = $clog2(NREGS);

  typedef logic [WIDTH-1:0] word_t;

  word_t         regs_q [NREGS];
  word_t         regs_d [NREGS];
  state_e        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  word_t         latch_q, latch_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic  waddr_ok, raddr_ok, src_ok, dst_ok;
  word_t wr_cur, wr_nxt, rd_data;
  logic  wr_valid;

  assign waddr_ok = addr_in_range(32'(bus.waddr), NREGS);
  assign raddr_ok = addr_in_range(32'(bus.raddr), NREGS);
  assign src_ok   = addr_in_range(32'(src_q), NREGS);
  assign dst_ok   = addr_in_range(32'(dst_q), NREGS);

  assign wr_cur = waddr_ok ? regs_q[bus.waddr] : '0;

  reg_mode_unit #(.WIDTH(WIDTH)) u_mode (
    .mode     (bus.mode),
    .cur      (wr_cur),
    .d        (bus.D),
    .nxt      (wr_nxt),
    .wr_valid (wr_valid)
  );

  always_comb begin
    regs_d  = regs_q;
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    latch_d = latch_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A Wn op wins over a simultaneous start; the start is dropped.
        if (!bus.Wn) begin
          if (waddr_ok && wr_valid) regs_d[bus.waddr] = wr_nxt;
        end else if (bus.start) begin
          src_d   = bus.src;
          dst_d   = bus.dst;
          busy_d  = 1'b1;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        latch_d = src_ok ? regs_q[src_q] : '0;
        state_d = ST_WR;
      end
      ST_WR: begin
        // A bad src or dst still completes the sequence but commits nothing.
        if (src_ok && dst_ok) regs_d[dst_q] = latch_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs_q  <= '{default: '0};
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      latch_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      latch_q <= latch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rd_data  = raddr_ok ? regs_q[bus.raddr] : '0;
  assign bus.Q    = rd_data;
  assign bus.zero = (rd_data == '0);
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
